// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: register map,
// FSM states, bus payload and the NTSC/PAL counter profile table.
package pll_reconfig_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TBL_LEN = 5;

  localparam logic [ADDR_W-1:0] REG_MODE   = 6'h00;
  localparam logic [ADDR_W-1:0] REG_STATUS = 6'h01;
  localparam logic [ADDR_W-1:0] REG_START  = 6'h02;
  localparam logic [ADDR_W-1:0] REG_N      = 6'h03;
  localparam logic [ADDR_W-1:0] REG_M      = 6'h04;
  localparam logic [ADDR_W-1:0] REG_C      = 6'h05;
  localparam logic [ADDR_W-1:0] REG_K      = 6'h07;

  // C-counter writes carry the counter select in bits [22:18]
  localparam int unsigned C_SEL_LSB = 18;
  localparam logic [4:0]  C_SEL_C0  = 5'd0;
  localparam logic [4:0]  C_SEL_C1  = 5'd1;

  // Counter words: {odd[17], bypass[16], high[15:8], low[7:0]}.
  // 50 MHz ref, N=1, VCO = 50*M.K; C0=/10, C1=/5.
  localparam logic [DATA_W-1:0] M_NTSC  = 32'h0002_0605;  // M=11
  localparam logic [DATA_W-1:0] M_PAL   = 32'h0000_0505;  // M=10
  localparam logic [DATA_W-1:0] N_ALL   = 32'h0001_0000;  // bypass, N=1
  localparam logic [DATA_W-1:0] C0_ALL  = {9'd0, C_SEL_C0, 18'h0_0505};
  localparam logic [DATA_W-1:0] C1_ALL  = {9'd0, C_SEL_C1, 18'h2_0302};
  localparam logic [DATA_W-1:0] K_NTSC  = 32'd1952251615; // .454544
  localparam logic [DATA_W-1:0] K_PAL   = 32'd2751721122; // .640685

  typedef enum logic [2:0] {
    ST_WR_MODE,
    ST_WR_TBL,
    ST_WR_START,
    ST_POLL,
    ST_WAIT_LOCK,
    ST_IDLE
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mgmt_wr_t;

  // 2x5 profile table: entry idx of profile pal (0=NTSC, 1=PAL)
  function automatic mgmt_wr_t profile_entry(input logic pal, input logic [2:0] idx);
    mgmt_wr_t e;
    e = {REG_MODE, 32'h0};
    case (idx)
      3'd0:    e = {REG_M, pal ? M_PAL : M_NTSC};
      3'd1:    e = {REG_N, N_ALL};
      3'd2:    e = {REG_C, C0_ALL};
      3'd3:    e = {REG_C, C1_ALL};
      3'd4:    e = {REG_K, pal ? K_PAL : K_NTSC};
      default: e = {REG_MODE, 32'h0};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq_lock_filter.sv
// Lock qualifier: counts consecutive locked cycles while enabled.
import pll_reconfig_pkg::*;

module pll_lock_filter #(
  parameter int unsigned LOCK_STABLE = 1024
) (
  input  logic refclk,
  input  logic rst,
  input  logic en,
  input  logic pll_locked,
  output logic stable_c
);

  localparam int unsigned CNT_W = $clog2(LOCK_STABLE) + 1;

  logic [CNT_W-1:0] cnt_q;

  // Any unlocked cycle (or disable) restarts the run from zero
  always_ff @(posedge refclk) begin
    if (rst || !en || !pll_locked) begin
      cnt_q <= '0;
    end else if (!stable_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stable_c = en && pll_locked && (cnt_q == CNT_W'(LOCK_STABLE - 1));

endmodule

// File: rtl/pll_reconfig_seq.sv
// PLL reconfiguration sequencer: writes the NTSC/PAL counter profile through
// the mgmt port, polls completion, waits for a stable lock, then releases
// core_rst. Optional timeout/err logic under `PLL_TIMEOUT_EN.
import pll_reconfig_pkg::*;

module pll_reconfig_seq #(
  parameter int unsigned LOCK_STABLE = 1024
`ifdef PLL_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYC = 5000000
`endif
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              pal_mode,
  input  logic              pll_locked,
  output logic [ADDR_W-1:0] mgmt_address,
  output logic              mgmt_write,
  output logic              mgmt_read,
  output logic [DATA_W-1:0] mgmt_writedata,
  input  logic [DATA_W-1:0] mgmt_readdata,
  input  logic              mgmt_waitrequest,
  output logic              core_rst,
  output logic              busy,
  output logic              cur_mode,
  output logic              lock_lost,
  output logic              err
);

  state_e            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic              target_q, target_d;
  logic              wr_q, wr_d, rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              core_rst_q, core_rst_d, busy_q, busy_d;
  logic              cur_mode_q, cur_mode_d, lock_lost_q, lock_lost_d;
  logic              err_q, err_d;
  logic              stable_c;
  mgmt_wr_t          entry_c;
  logic              unused_rdata;

`ifdef PLL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

  assign unused_rdata = ^mgmt_readdata[DATA_W-1:1];

  pll_lock_filter #(.LOCK_STABLE(LOCK_STABLE)) u_lock_filter (
    .refclk     (refclk),
    .rst        (rst),
    .en         (state_q == ST_WAIT_LOCK),
    .pll_locked (pll_locked),
    .stable_c   (stable_c)
  );

  // State and registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q     <= ST_WR_MODE;
      idx_q       <= '0;
      target_q    <= pal_mode;
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      core_rst_q  <= 1'b1;
      busy_q      <= 1'b1;
      cur_mode_q  <= 1'b0;
      lock_lost_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef PLL_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      target_q    <= target_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      core_rst_q  <= core_rst_d;
      busy_q      <= busy_d;
      cur_mode_q  <= cur_mode_d;
      lock_lost_q <= lock_lost_d;
      err_q       <= err_d;
`ifdef PLL_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  // Next-state: a transfer is issued only from a strobe-low cycle, so every
  // acceptance is followed by at least one idle cycle
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    target_d    = target_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    core_rst_d  = core_rst_q;
    busy_d      = busy_q;
    cur_mode_d  = cur_mode_q;
    lock_lost_d = lock_lost_q;
    err_d       = err_q;
    entry_c     = profile_entry(target_q, idx_q);

    case (state_q)
      ST_WR_MODE: begin
        if (wr_q) begin
          if (!mgmt_waitrequest) begin
            wr_d    = 1'b0;
            idx_d   = '0;
            state_d = ST_WR_TBL;
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = REG_MODE;
          wdata_d = 32'h1;
        end
      end
      ST_WR_TBL: begin
        if (wr_q) begin
          if (!mgmt_waitrequest) begin
            wr_d = 1'b0;
            if (idx_q == 3'(TBL_LEN - 1)) begin
              idx_d   = '0;
              state_d = ST_WR_START;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = entry_c.addr;
          wdata_d = entry_c.data;
        end
      end
      ST_WR_START: begin
        if (wr_q) begin
          if (!mgmt_waitrequest) begin
            wr_d    = 1'b0;
            state_d = ST_POLL;
          end
        end else begin
          wr_d    = 1'b1;
          addr_d  = REG_START;
          wdata_d = 32'h1;
        end
      end
      ST_POLL: begin
        if (rd_q) begin
          if (!mgmt_waitrequest) begin
            rd_d = 1'b0;
            if (mgmt_readdata[0]) state_d = ST_WAIT_LOCK;
          end
        end else begin
          rd_d   = 1'b1;
          addr_d = REG_STATUS;
        end
      end
      ST_WAIT_LOCK: begin
        if (stable_c) begin
          state_d    = ST_IDLE;
          cur_mode_d = target_q;
          core_rst_d = 1'b0;
          busy_d     = 1'b0;
        end
      end
      ST_IDLE: begin
        if (!pll_locked) begin
          lock_lost_d = 1'b1;
          core_rst_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_WAIT_LOCK;
        end else if (pal_mode != cur_mode_q) begin
          target_d    = pal_mode;
          lock_lost_d = 1'b0;
          core_rst_d  = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_WR_MODE;
        end
      end
      default: state_d = ST_WR_MODE;
    endcase

`ifdef PLL_TIMEOUT_EN
    // One budget spans POLL and WAIT_LOCK; expiry restarts with the same target
    to_cnt_d = '0;
    if (state_q == ST_POLL || state_q == ST_WAIT_LOCK) begin
      to_cnt_d = to_cnt_q + TO_W'(1);
      if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
        to_cnt_d   = '0;
        err_d      = 1'b1;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        core_rst_d = 1'b1;
        busy_d     = 1'b1;
        state_d    = ST_WR_MODE;
      end
    end
`endif
  end

  assign mgmt_address   = addr_q;
  assign mgmt_write     = wr_q;
  assign mgmt_read      = rd_q;
  assign mgmt_writedata = wdata_q;
  assign core_rst       = core_rst_q;
  assign busy           = busy_q;
  assign cur_mode       = cur_mode_q;
  assign lock_lost      = lock_lost_q;
  assign err            = err_q;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Directed bench for pll_reconfig_seq (LOCK_STABLE=16). With PLL_TIMEOUT_EN
// defined, TIMEOUT_CYC=100 and the timeout step is included.
module tb_pll_reconfig_seq;

  localparam int unsigned LOCK_STABLE = 16;

  logic        refclk = 1'b0;
  logic        rst, pal_mode, pll_locked, mgmt_waitrequest;
  logic        mgmt_write, mgmt_read, core_rst, busy, cur_mode, lock_lost, err;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata, mgmt_readdata;
  int          nchk = 0;
  int          nerr = 0;

  always #5 refclk = ~refclk;

  pll_reconfig_seq #(
    .LOCK_STABLE(LOCK_STABLE)
`ifdef PLL_TIMEOUT_EN
    , .TIMEOUT_CYC(100)
`endif
  ) dut (
    .refclk(refclk), .rst(rst), .pal_mode(pal_mode), .pll_locked(pll_locked),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
    .mgmt_writedata(mgmt_writedata), .mgmt_readdata(mgmt_readdata),
    .mgmt_waitrequest(mgmt_waitrequest), .core_rst(core_rst), .busy(busy),
    .cur_mode(cur_mode), .lock_lost(lock_lost), .err(err)
  );

  task automatic check1(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected profile table, written out independently of the design package
  function automatic logic [5:0] exp_addr(input int i);
    case (i)
      0: return 6'h04;
      1: return 6'h03;
      2: return 6'h05;
      3: return 6'h05;
      default: return 6'h07;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input logic pal, input int i);
    case (i)
      0: return pal ? 32'h0000_0505 : 32'h0002_0605;
      1: return 32'h0001_0000;
      2: return 32'h0000_0505;
      3: return 32'h0006_0302;
      default: return pal ? 32'd2751721122 : 32'd1952251615;
    endcase
  endfunction

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!(mgmt_write || mgmt_read) && n < 300) begin
      @(negedge refclk);
      n++;
    end
    check1({tag, " strobe seen"}, mgmt_write | mgmt_read, 1'b1);
  endtask

  // Accept one transfer after 'waits' stalled cycles; checks hold and drop
  task automatic do_xfer(input string tag, input logic is_wr, input logic [5:0] a,
                         input logic [31:0] d, input int waits, input logic [31:0] rdata);
    logic held;
    wait_strobe(tag);
    check1({tag, " wr"}, mgmt_write, is_wr);
    check1({tag, " rd"}, mgmt_read, ~is_wr);
    check32({tag, " addr"}, 32'(mgmt_address), 32'(a));
    if (is_wr) check32({tag, " data"}, mgmt_writedata, d);
    mgmt_readdata    = rdata;
    mgmt_waitrequest = (waits != 0);
    held = 1'b1;
    for (int i = 0; i < waits; i++) begin
      @(negedge refclk);
      held = held & (mgmt_write === is_wr) & (mgmt_read === ~is_wr) & (mgmt_address === a)
             & (!is_wr || mgmt_writedata === d);
    end
    if (waits != 0) check1({tag, " held"}, held, 1'b1);
    mgmt_waitrequest = 1'b0;
    @(negedge refclk);
    check1({tag, " drop"}, mgmt_write | mgmt_read, 1'b0);
  endtask

  // Full write/poll sequence; 'toggle' flips pal_mode twice inside WR_TBL
  task automatic run_seq(input string tag, input logic pal, input int waits,
                         input int not_done, input logic toggle);
    do_xfer({tag, " mode"}, 1'b1, 6'h00, 32'h1, waits, 32'h0);
    for (int i = 0; i < 5; i++) begin
      do_xfer({tag, " tbl"}, 1'b1, exp_addr(i), exp_data(pal, i), waits, 32'h0);
      if (toggle && (i == 1 || i == 3)) pal_mode = ~pal_mode;
    end
    do_xfer({tag, " start"}, 1'b1, 6'h02, 32'h1, waits, 32'h0);
    for (int i = 0; i < not_done; i++)
      do_xfer({tag, " poll0"}, 1'b0, 6'h01, 32'h0, waits, 32'hFFFF_FFFE);
    do_xfer({tag, " poll1"}, 1'b0, 6'h01, 32'h0, waits, 32'h0000_0001);
  endtask

  // Called on the first WAIT_LOCK cycle with locked already high
  task automatic wait_relock(input string tag);
    logic early = 1'b0;
    for (int i = 0; i < int'(LOCK_STABLE) - 1; i++) begin
      @(negedge refclk);
      if (core_rst !== 1'b1 || mgmt_write !== 1'b0 || mgmt_read !== 1'b0) early = 1'b1;
    end
    check1({tag, " held in reset"}, early, 1'b0);
    @(negedge refclk);
    check1({tag, " core_rst"}, core_rst, 1'b0);
    check1({tag, " busy"}, busy, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; pal_mode = 1'b0; pll_locked = 1'b0;
    mgmt_waitrequest = 1'b0; mgmt_readdata = 32'h0;
    repeat (3) @(negedge refclk);
    check1("rst write", mgmt_write, 1'b0);
    check1("rst read", mgmt_read, 1'b0);
    check32("rst addr", 32'(mgmt_address), 32'h0);
    check32("rst wdata", mgmt_writedata, 32'h0);
    check1("rst core_rst", core_rst, 1'b1);
    check1("rst busy", busy, 1'b1);
    check1("rst cur_mode", cur_mode, 1'b0);
    check1("rst lock_lost", lock_lost, 1'b0);
    check1("rst err", err, 1'b0);
    rst = 1'b0;

    // NTSC after reset, no stalls, one not-done poll, lock arrives later
    run_seq("t1", 1'b0, 0, 1, 1'b0);
    pll_locked = 1'b1;
    wait_relock("t1 lock");
    check1("t1 cur_mode", cur_mode, 1'b0);
    check1("t1 lock_lost", lock_lost, 1'b0);
    check1("t1 err", err, 1'b0);

    // One-cycle lock drop in IDLE
    repeat (3) @(negedge refclk);
    pll_locked = 1'b0;
    @(negedge refclk);
    pll_locked = 1'b1;
    check1("t5 lock_lost", lock_lost, 1'b1);
    check1("t5 core_rst", core_rst, 1'b1);
    wait_relock("t5 relock");
    check1("t5 lock_lost sticky", lock_lost, 1'b1);
    check1("t5 cur_mode", cur_mode, 1'b0);

    // Switch to PAL, with pal_mode glitching mid-table
    pal_mode = 1'b1;
    @(negedge refclk);
    check1("t3 busy", busy, 1'b1);
    check1("t3 core_rst", core_rst, 1'b1);
    check1("t3 lock_lost clr", lock_lost, 1'b0);
    run_seq("t3", 1'b1, 1, 0, 1'b1);
    wait_relock("t3 lock");
    check1("t3 cur_mode", cur_mode, 1'b1);
    repeat (5) @(negedge refclk);
    check1("t4 no restart busy", busy, 1'b0);
    check1("t4 no restart strobe", mgmt_write | mgmt_read, 1'b0);

    // Back to NTSC with three stall cycles per transfer
    pal_mode = 1'b0;
    run_seq("t2", 1'b0, 3, 2, 1'b0);
    wait_relock("t2 lock");
    check1("t2 cur_mode", cur_mode, 1'b0);

    // Reset while a write is stalled
    pal_mode = 1'b1;
    mgmt_waitrequest = 1'b1;
    wait_strobe("rst mid");
    check1("rst mid wr", mgmt_write, 1'b1);
    rst = 1'b1;
    @(negedge refclk);
    check1("rst mid wr drop", mgmt_write, 1'b0);
    check1("rst mid rd", mgmt_read, 1'b0);
    check1("rst mid cur_mode", cur_mode, 1'b0);
    check1("rst mid core_rst", core_rst, 1'b1);
    rst = 1'b0;
    mgmt_waitrequest = 1'b0;

`ifdef PLL_TIMEOUT_EN
    // Lock never arrives: timeout after 100 cycles in POLL/WAIT_LOCK
    pll_locked = 1'b0;
    do_xfer("t6 mode", 1'b1, 6'h00, 32'h1, 0, 32'h0);
    for (int i = 0; i < 5; i++)
      do_xfer("t6 tbl", 1'b1, exp_addr(i), exp_data(1'b1, i), 0, 32'h0);
    do_xfer("t6 start", 1'b1, 6'h02, 32'h1, 0, 32'h0);
    mgmt_readdata = 32'h1;
    repeat (99) @(negedge refclk);
    check1("t6 err before", err, 1'b0);
    @(negedge refclk);
    check1("t6 err", err, 1'b1);
    do_xfer("t6 reissue", 1'b1, 6'h00, 32'h1, 0, 32'h0);
    check1("t6 err sticky", err, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
